// File: rtl/iec_host_tx.sv
// IEC serial-bus host byte transmitter (talker side): ATN framing, device-present check, EOI, per-bit clocking, frame ack.
// Optional ready-for-data watchdog in RTS is compiled in with `define IEC_WATCHDOG_EN.
module iec_host_tx #(
  parameter int T_SETUP  = 20,
  parameter int T_BIT    = 60,
  parameter int T_EOI    = 250,
  parameter int T_ACK_TO = 1000,
  parameter int T_RFD_TO = 65000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       atn,
  input  logic       eoi,
  input  logic       atn_end,
  input  logic       iec_clk_i,
  input  logic       iec_data_i,
  output logic       iec_atn_o,
  output logic       iec_clk_o,
  output logic       iec_data_o,
  output logic       busy,
  output logic       done,
  output logic [1:0] status,
  output logic [5:0] dbg_o
);

  // Handshake: start and atn_end are one-cycle requests honoured only while busy=0, and start
  // beats atn_end in the same cycle. done pulses for one cycle as busy drops; status is valid
  // from that cycle until the next accepted start.

  typedef enum logic [3:0] {
    S_IDLE,
    S_ATN_ASSERT,
    S_RTS,
    S_EOI_WAIT,
    S_EOI_REL,
    S_BIT_SETUP,
    S_BIT_VALID,
    S_FRAME_ACK,
    S_FINISH
  } state_t;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_NODEV = 2'd1;
  localparam logic [1:0] ST_FRAME = 2'd2;
`ifdef IEC_WATCHDOG_EN
  localparam logic [1:0] ST_WDOG  = 2'd3;
  localparam logic [15:0] LIM_RFD = 16'(T_RFD_TO - 1);
`endif

  localparam logic [15:0] LIM_SETUP  = 16'(T_SETUP - 1);
  localparam logic [15:0] LIM_BIT    = 16'(T_BIT - 1);
  localparam logic [15:0] LIM_ACK    = 16'(T_ACK_TO - 1);
  localparam logic [15:0] LIM_EOI_TO = 16'(T_EOI + T_ACK_TO - 1);

  state_t      state_q;
  logic [15:0] timer_q;
  logic [1:0]  settle_q;
  logic [2:0]  bit_q;
  logic [7:0]  din_q;
  logic        eoi_q;
  logic [1:0]  clk_sync_q;
  logic [1:0]  data_sync_q;

  logic data_s;
  logic settled;
  logic exp_setup;
  logic exp_bit;
  logic exp_ack;
  logic exp_eoi;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], iec_clk_i};
      data_sync_q <= {data_sync_q[0], iec_data_i};
    end
  end

  assign data_s = data_sync_q[1];
  // Our own DATA edges need two clk_sys to reach data_s; settled masks that window after entry.
  assign settled   = settle_q[1];
  assign exp_setup = ce && (timer_q >= LIM_SETUP);
  assign exp_bit   = ce && (timer_q >= LIM_BIT);
  assign exp_ack   = ce && (timer_q >= LIM_ACK);
  assign exp_eoi   = ce && (timer_q >= LIM_EOI_TO);
`ifdef IEC_WATCHDOG_EN
  logic exp_rfd;
  assign exp_rfd = ce && (timer_q >= LIM_RFD);
`endif

  assign dbg_o = {clk_sync_q[1], data_sync_q[1], state_q};

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      settle_q   <= '0;
      bit_q      <= '0;
      din_q      <= '0;
      eoi_q      <= 1'b0;
      iec_atn_o  <= 1'b1;
      iec_clk_o  <= 1'b1;
      iec_data_o <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      status     <= ST_OK;
    end else begin
      done <= 1'b0;
      if (ce && (timer_q != 16'hFFFF)) timer_q <= timer_q + 16'd1;
      if (!settle_q[1]) settle_q <= settle_q + 2'd1;

      case (state_q)
        S_IDLE, S_FINISH: begin
          state_q  <= S_IDLE;
          timer_q  <= '0;
          settle_q <= '0;
          if (start) begin
            din_q  <= din;
            eoi_q  <= eoi;
            bit_q  <= '0;
            busy   <= 1'b1;
            status <= ST_OK;
            if (atn) begin
              state_q    <= S_ATN_ASSERT;
              iec_atn_o  <= 1'b0;
              iec_clk_o  <= 1'b0;
              iec_data_o <= 1'b1;
            end else begin
              state_q    <= S_RTS;
              iec_clk_o  <= 1'b1;
              iec_data_o <= 1'b1;
            end
          end else if (atn_end) begin
            iec_atn_o  <= 1'b1;
            iec_clk_o  <= 1'b1;
            iec_data_o <= 1'b1;
          end
        end

        S_ATN_ASSERT: begin
          if (settled && !data_s) begin
            state_q   <= S_RTS;
            iec_clk_o <= 1'b1;
            timer_q   <= '0;
            settle_q  <= '0;
          end else if (exp_ack) begin
            status     <= ST_NODEV;
            iec_atn_o  <= 1'b1;
            iec_clk_o  <= 1'b1;
            iec_data_o <= 1'b1;
            state_q    <= S_FINISH;
            busy       <= 1'b0;
            done       <= 1'b1;
            timer_q    <= '0;
          end
        end

        S_RTS: begin
          if (settled && data_s) begin
            timer_q  <= '0;
            settle_q <= '0;
            if (eoi_q) begin
              state_q <= S_EOI_WAIT;
            end else begin
              state_q    <= S_BIT_SETUP;
              iec_clk_o  <= 1'b0;
              iec_data_o <= din_q[0];
            end
          end
`ifdef IEC_WATCHDOG_EN
          else if (exp_rfd) begin
            status     <= ST_WDOG;
            iec_atn_o  <= 1'b1;
            iec_clk_o  <= 1'b1;
            iec_data_o <= 1'b1;
            state_q    <= S_FINISH;
            busy       <= 1'b0;
            done       <= 1'b1;
            timer_q    <= '0;
          end
`endif
        end

        S_EOI_WAIT: begin
          if (!data_s) begin
            state_q  <= S_EOI_REL;
            timer_q  <= '0;
            settle_q <= '0;
          end else if (exp_eoi) begin
            status     <= ST_FRAME;
            iec_atn_o  <= 1'b1;
            iec_clk_o  <= 1'b1;
            iec_data_o <= 1'b1;
            state_q    <= S_FINISH;
            busy       <= 1'b0;
            done       <= 1'b1;
            timer_q    <= '0;
          end
        end

        S_EOI_REL: begin
          if (settled && data_s) begin
            state_q    <= S_BIT_SETUP;
            iec_clk_o  <= 1'b0;
            iec_data_o <= din_q[0];
            timer_q    <= '0;
            settle_q   <= '0;
          end
        end

        S_BIT_SETUP: begin
          if (exp_setup) begin
            state_q   <= S_BIT_VALID;
            iec_clk_o <= 1'b1;
            timer_q   <= '0;
            settle_q  <= '0;
          end
        end

        S_BIT_VALID: begin
          if (exp_bit) begin
            iec_clk_o <= 1'b0;
            timer_q   <= '0;
            settle_q  <= '0;
            if (bit_q == 3'd7) begin
              state_q    <= S_FRAME_ACK;
              iec_data_o <= 1'b1;
            end else begin
              // Next bit goes straight onto DATA as CLK falls, opening its setup window.
              state_q    <= S_BIT_SETUP;
              bit_q      <= bit_q + 3'd1;
              iec_data_o <= din_q[bit_q + 3'd1];
            end
          end
        end

        S_FRAME_ACK: begin
          if (settled && !data_s) begin
            status    <= ST_OK;
            iec_clk_o <= eoi_q;
            state_q   <= S_FINISH;
            busy      <= 1'b0;
            done      <= 1'b1;
            timer_q   <= '0;
          end else if (exp_ack) begin
            status     <= ST_FRAME;
            iec_atn_o  <= 1'b1;
            iec_clk_o  <= 1'b1;
            iec_data_o <= 1'b1;
            state_q    <= S_FINISH;
            busy       <= 1'b0;
            done       <= 1'b1;
            timer_q    <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iec_host_tx.sv
// Bench for iec_host_tx: a behavioural listener drives the bus, a monitor decodes bytes from
// CLK-high windows, and each scenario compares against bytes/status/line levels from the protocol rules.
module tb_iec_host_tx;
  localparam int T_SETUP  = 20;
  localparam int T_BIT    = 60;
  localparam int T_EOI    = 250;
  localparam int T_ACK_TO = 1000;
  localparam int T_RFD_TO = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       atn = 1'b0;
  logic       eoi = 1'b0;
  logic       atn_end = 1'b0;
  logic       lst_data = 1'b1;
  logic       iec_atn_o, iec_clk_o, iec_data_o, busy, done;
  logic [1:0] status;
  logic [5:0] dbg;
  wire        bus_clk  = iec_clk_o;
  wire        bus_data = iec_data_o & lst_data;

  iec_host_tx #(.T_SETUP(T_SETUP), .T_BIT(T_BIT), .T_EOI(T_EOI), .T_ACK_TO(T_ACK_TO),
                .T_RFD_TO(T_RFD_TO)) dut (
    .clk_sys(clk), .reset_n(reset_n), .ce(ce), .start(start), .din(din), .atn(atn), .eoi(eoi),
    .atn_end(atn_end), .iec_clk_i(bus_clk), .iec_data_i(bus_data), .iec_atn_o(iec_atn_o),
    .iec_clk_o(iec_clk_o), .iec_data_o(iec_data_o), .busy(busy), .done(done), .status(status),
    .dbg_o(dbg));

  // clock / reset / tick base
  always #5 clk = ~clk;
  always @(negedge clk) ce <= ~ce;

  int unsigned tick = 0;
  always @(posedge clk) if (ce) tick <= tick + 1;

  int total = 0;
  int bad = 0;

  // scoreboard and monitor
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int unsigned rise_tick = 0, fall_tick = 0, done_tick = 0, start_tick = 0;
  int          done_cnt = 0;
  int          mon_bits = 0;
  logic [7:0]  mon_sh = 8'h00;
  logic        rise_data = 1'b1;
  logic        prev_clk = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (start && !busy) begin mon_bits = 0; start_tick = tick; end
      if (done) begin done_cnt++; done_tick = tick; end
      if (iec_clk_o && !prev_clk) begin rise_tick = tick; rise_data = bus_data; end
      if (!iec_clk_o && prev_clk) begin
        fall_tick = tick;
        if (busy && (tick - rise_tick) >= T_BIT - 1 && (tick - rise_tick) <= T_BIT + 1) begin
          mon_sh = {rise_data, mon_sh[7:1]};
          mon_bits++;
          if (mon_bits == 8) got_q.push_back(mon_sh);
        end
      end
      prev_clk = iec_clk_o;
    end
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin @(posedge clk); if (ce) k++; end
    #1;
  endtask

  task automatic wait_clk(input logic lvl, output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (iec_clk_o === lvl) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_atn_low(output bit ok);
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      if (iec_atn_o === 1'b0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start(input logic [7:0] d, input logic a, input logic e, input logic with_end);
    @(posedge clk); #1;
    din = d; atn = a; eoi = e; start = 1'b1; atn_end = with_end;
    @(posedge clk); #1;
    start = 1'b0; atn_end = 1'b0;
  endtask

  task automatic pulse_atn_end();
    @(posedge clk); #1; atn_end = 1'b1;
    @(posedge clk); #1; atn_end = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
  endtask

  // Listener: device-present pull under ATN, ready-for-data release, EOI ack, frame ack.
  task automatic listener(input logic is_atn, input logic is_eoi, input int rfd_delay,
                          input bit ack, input int ack_delay);
    bit ok;
    if (is_atn) begin
      wait_atn_low(ok); if (!ok) return;
      wait_ticks(100); lst_data = 1'b0;
    end
    wait_clk(1'b1, ok); if (!ok) return;
    wait_ticks(rfd_delay); lst_data = 1'b1;
    if (is_eoi) begin
      wait_ticks(T_EOI + 10); lst_data = 1'b0;
      wait_ticks(60); lst_data = 1'b1;
    end
    wait_clk(1'b0, ok); if (!ok) return;
    for (int b = 0; b < 8; b++) begin
      wait_clk(1'b1, ok); if (!ok) return;
      wait_clk(1'b0, ok); if (!ok) return;
    end
    wait_ticks(ack_delay);
    if (ack) lst_data = 1'b0;
  endtask

  task automatic run_xfer(input logic [7:0] d, input logic a, input logic e, input bit present,
                          input bit ack, input logic with_end, input bit inject, output bit ok);
    int rfd = $urandom_range(5, 50);
    int ackd = $urandom_range(10, 400);
    got_q.delete(); done_cnt = 0;
    fork
      begin pulse_start(d, a, e, with_end); wait_done(ok); end
      begin if (present) listener(a, e, rfd, ack, ackd); end
      begin if (inject) begin wait_ticks(300); pulse_start(~d, 1'b1, 1'b0, 1'b1); end end
    join
    @(negedge clk);
  endtask

  // scenarios
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if ({iec_atn_o, iec_clk_o, iec_data_o, busy, done, status} !== 7'b1110000) begin
      bad++; $display("FAIL reset_outputs got=%b exp=1110000", {iec_atn_o, iec_clk_o, iec_data_o, busy, done, status}); end
    @(posedge clk); #1; reset_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if ({iec_atn_o, iec_clk_o, iec_data_o, busy, done, status} !== 7'b1110000) begin
      bad++; $display("FAIL post_reset_idle got=%b exp=1110000", {iec_atn_o, iec_clk_o, iec_data_o, busy, done, status}); end
    total++; if (dbg[5:4] !== 2'b11) begin
      bad++; $display("FAIL sync_bus_idle got=%b exp=11", dbg[5:4]); end
    $display("info: state code after reset = %0d", dbg[3:0]);
  endtask

  task automatic test_atn_byte();
    bit ok;
    lst_data = 1'b1;
    exp_q.delete(); exp_q.push_back(8'h28);
    run_xfer(8'h28, 1'b1, 1'b0, 1, 1, 1'b0, 0, ok);
    total++; if (!ok) begin bad++; $display("FAIL atn_done_timeout got=none exp=done"); end
    total++; if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL atn_byte got=%h (n=%0d) exp=%h", (got_q.size() > 0) ? got_q[0] : 8'hxx, got_q.size(), exp_q[0]); end
    total++; if (status !== 2'd0) begin bad++; $display("FAIL atn_status got=%0d exp=0", status); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL atn_done_count got=%0d exp=1", done_cnt); end
    total++; if ({iec_atn_o, iec_clk_o, iec_data_o, busy} !== 4'b0010) begin
      bad++; $display("FAIL atn_end_lines got=%b exp=0010", {iec_atn_o, iec_clk_o, iec_data_o, busy}); end
  endtask

  task automatic test_busy_ignore();
    bit ok;
    logic [7:0] d = 8'($urandom_range(0, 255));
    run_xfer(d, 1'b0, 1'b0, 1, 1, 1'b0, 1, ok);
    total++; if (!ok || got_q.size() != 1 || got_q[0] !== d) begin
      bad++; $display("FAIL busy_ignore_byte got=%h (n=%0d ok=%0d) exp=%h", (got_q.size() > 0) ? got_q[0] : 8'hxx, got_q.size(), ok, d); end
    total++; if ({iec_atn_o, iec_clk_o, status} !== 4'b0000) begin
      bad++; $display("FAIL busy_ignore_lines got=%b exp=0000", {iec_atn_o, iec_clk_o, status}); end
  endtask

  task automatic test_start_wins();
    bit ok;
    logic [7:0] d = 8'($urandom_range(0, 255));
    run_xfer(d, 1'b0, 1'b0, 1, 1, 1'b1, 0, ok);
    total++; if (!ok || got_q.size() != 1 || got_q[0] !== d || status !== 2'd0) begin
      bad++; $display("FAIL start_wins_byte got=%h st=%0d ok=%0d exp=%h st=0", (got_q.size() > 0) ? got_q[0] : 8'hxx, status, ok, d); end
    total++; if (iec_atn_o !== 1'b0) begin bad++; $display("FAIL start_wins_atn got=%b exp=0", iec_atn_o); end
    pulse_atn_end();
    total++; if ({iec_atn_o, iec_clk_o, iec_data_o} !== 3'b111) begin
      bad++; $display("FAIL atn_end_release got=%b exp=111", {iec_atn_o, iec_clk_o, iec_data_o}); end
  endtask

  task automatic test_no_device();
    bit ok;
    int unsigned dt;
    lst_data = 1'b1;
    run_xfer(8'($urandom_range(0, 255)), 1'b1, 1'b0, 0, 0, 1'b0, 0, ok);
    dt = done_tick - start_tick;
    total++; if (!ok || status !== 2'd1) begin bad++; $display("FAIL nodev_status got=%0d ok=%0d exp=1", status, ok); end
    total++; if (dt < T_ACK_TO || dt > T_ACK_TO + 2) begin bad++; $display("FAIL nodev_time got=%0d exp=%0d", dt, T_ACK_TO); end
    total++; if ({iec_atn_o, iec_clk_o, iec_data_o, busy} !== 4'b1110) begin
      bad++; $display("FAIL nodev_lines got=%b exp=1110", {iec_atn_o, iec_clk_o, iec_data_o, busy}); end
  endtask

  task automatic test_eoi();
    bit ok;
    lst_data = 1'b0;
    run_xfer(8'h0D, 1'b0, 1'b1, 1, 1, 1'b0, 0, ok);
    total++; if (!ok || got_q.size() != 1 || got_q[0] !== 8'h0D) begin
      bad++; $display("FAIL eoi_byte got=%h (n=%0d ok=%0d) exp=0d", (got_q.size() > 0) ? got_q[0] : 8'hxx, got_q.size(), ok); end
    total++; if ({iec_atn_o, iec_clk_o, status} !== 4'b1100) begin
      bad++; $display("FAIL eoi_end got=%b exp=1100", {iec_atn_o, iec_clk_o, status}); end
  endtask

  task automatic test_frame_err();
    bit ok;
    int unsigned dt;
    logic [7:0] d = 8'($urandom_range(0, 255));
    lst_data = 1'b0;
    run_xfer(d, 1'b0, 1'b0, 1, 0, 1'b0, 0, ok);
    dt = done_tick - fall_tick;
    total++; if (!ok || status !== 2'd2) begin bad++; $display("FAIL frame_err_status got=%0d ok=%0d exp=2", status, ok); end
    total++; if (dt < T_ACK_TO || dt > T_ACK_TO + 1) begin bad++; $display("FAIL frame_err_time got=%0d exp=%0d", dt, T_ACK_TO); end
    total++; if (got_q.size() != 1 || got_q[0] !== d) begin
      bad++; $display("FAIL frame_err_byte got=%h (n=%0d) exp=%h", (got_q.size() > 0) ? got_q[0] : 8'hxx, got_q.size(), d); end
    total++; if ({iec_atn_o, iec_clk_o, iec_data_o} !== 3'b111) begin
      bad++; $display("FAIL frame_err_lines got=%b exp=111", {iec_atn_o, iec_clk_o, iec_data_o}); end
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    logic [7:0] d = 8'($urandom_range(0, 255));
    lst_data = 1'b1;
    pulse_start(d, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (mon_bits >= 3 && iec_clk_o) begin ok = 1; break; end
    end
    total++; if (!ok) begin bad++; $display("FAIL reset_mid_reach got=no_bit_valid exp=bit_valid"); end
    reset_n = 1'b0; #1;
    total++; if ({iec_atn_o, iec_clk_o, iec_data_o, busy, done} !== 5'b11100) begin
      bad++; $display("FAIL reset_mid_outputs got=%b exp=11100", {iec_atn_o, iec_clk_o, iec_data_o, busy, done}); end
    @(posedge clk); #1; reset_n = 1'b1;
    lst_data = 1'b0;
    d = 8'($urandom_range(0, 255));
    run_xfer(d, 1'b0, 1'b0, 1, 1, 1'b0, 0, ok);
    total++; if (!ok || got_q.size() != 1 || got_q[0] !== d || status !== 2'd0) begin
      bad++; $display("FAIL reset_mid_recover got=%h st=%0d ok=%0d exp=%h st=0", (got_q.size() > 0) ? got_q[0] : 8'hxx, status, ok, d); end
  endtask

  task automatic test_random();
    bit ok;
    for (int n = 0; n < 5; n++) begin
      logic [7:0] d = 8'($urandom_range(0, 255));
      logic a = 1'($urandom_range(0, 1));
      logic e = a ? 1'b0 : 1'($urandom_range(0, 1));
      pulse_atn_end();
      lst_data = a ? 1'b1 : 1'b0;
      run_xfer(d, a, e, 1, 1, 1'b0, 0, ok);
      total++; if (!ok || got_q.size() != 1 || got_q[0] !== d || status !== 2'd0) begin
        bad++; $display("FAIL random_byte[%0d] got=%h st=%0d ok=%0d exp=%h st=0", n, (got_q.size() > 0) ? got_q[0] : 8'hxx, status, ok, d); end
      total++; if ({iec_atn_o, iec_clk_o, iec_data_o} !== {~a, e, 1'b1}) begin
        bad++; $display("FAIL random_lines[%0d] got=%b exp=%b", n, {iec_atn_o, iec_clk_o, iec_data_o}, {~a, e, 1'b1}); end
    end
  endtask

  task automatic test_watchdog();
    pulse_atn_end();
    lst_data = 1'b0;
`ifdef IEC_WATCHDOG_EN
    begin
      bit ok;
      int unsigned dt;
      run_xfer(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0, 0, 1'b0, 0, ok);
      dt = done_tick - start_tick;
      total++; if (!ok || status !== 2'd3) begin bad++; $display("FAIL wdog_status got=%0d ok=%0d exp=3", status, ok); end
      total++; if (dt < T_RFD_TO || dt > T_RFD_TO + 2) begin bad++; $display("FAIL wdog_time got=%0d exp=%0d", dt, T_RFD_TO); end
      total++; if ({iec_atn_o, iec_clk_o, iec_data_o, busy} !== 4'b1110) begin
        bad++; $display("FAIL wdog_lines got=%b exp=1110", {iec_atn_o, iec_clk_o, iec_data_o, busy}); end
    end
`else
    done_cnt = 0;
    pulse_start(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    wait_ticks(3 * T_RFD_TO);
    total++; if (busy !== 1'b1 || done_cnt != 0) begin
      bad++; $display("FAIL rts_wait_forever got busy=%b done=%0d exp busy=1 done=0", busy, done_cnt); end
    reset_n = 1'b0; #1;
    @(posedge clk); #1; reset_n = 1'b1;
`endif
    lst_data = 1'b1;
  endtask

  initial begin
    test_reset();
    test_atn_byte();
    test_busy_ignore();
    test_start_wins();
    test_no_device();
    test_eoi();
    test_frame_err();
    test_reset_mid();
    test_random();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
